// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings and flag bit positions for the alu_seq block.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_SLA = 4'h7,
        OP_SRA = 4'h8,
        OP_SRL = 4'h9,
        OP_MUL = 4'hA
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Positions inside the {neg, zero, carry, ovf} flag vector
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// low WIDTH bits of the product kept.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end else begin
                // Product has been handed to the top this cycle
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result stage. Define ALU_SEQ_MUL_EN to build
// the multi-cycle MUL opcode; otherwise opcode 1010 is reported as illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err
);

    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       flags_q;
    logic             err_q;

    logic             xfer;
    logic             is_mul;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;
    logic             err_d;
    logic [WIDTH:0]   sum_w;
    logic             carry_w;
    logic             ovf_w;
    logic [SHW-1:0]   sh;
    logic signed [WIDTH-1:0] op1_s;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        logic [3:0] f;
        f             = '0;
        f[FLAG_NEG]   = r[WIDTH-1];
        f[FLAG_ZERO]  = (r == '0);
        f[FLAG_CARRY] = c;
        f[FLAG_OVF]   = v;
        return f;
    endfunction

    assign op1_s     = inp1;
    assign sh        = inp2[SHW-1:0];
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign out       = out_q;
    assign flags     = flags_q;
    assign err       = err_q;

    always_comb begin
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        res_d   = '0;
        sum_w   = '0;
        carry_w = 1'b0;
        ovf_w   = 1'b0;
        err_d   = 1'b0;
        is_mul  = 1'b0;
        case (func)
            OP_ADD: begin
                sum_w   = {1'b0, inp1} + {1'b0, inp2};
                res_d   = sum_w[WIDTH-1:0];
                carry_w = sum_w[WIDTH];
                ovf_w   = (inp1[WIDTH-1] == inp2[WIDTH-1]) && (res_d[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = inp1 - inp2;
                carry_w = (inp1 < inp2);
                ovf_w   = (inp1[WIDTH-1] != inp2[WIDTH-1]) && (res_d[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_AND: res_d = inp1 & inp2;
            OP_OR:  res_d = inp1 | inp2;
            OP_XOR: res_d = inp1 ^ inp2;
            OP_NOT: res_d = ~inp1;
            OP_SLA: res_d = inp1 << sh;
            OP_SRA: res_d = op1_s >>> sh;
            OP_SRL: res_d = inp1 >> sh;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            default: err_d = 1'b1;
        endcase
        flags_d = err_d ? 4'b0000 : mk_flags(res_d, carry_w, ovf_w);
    end

`ifdef ALU_SEQ_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (xfer && is_mul),
        .a_i       (inp1),
        .b_i       (inp2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (xfer) begin
                        if (is_mul) begin
                            state_q <= ST_MUL;
                        end else begin
                            state_q <= ST_HOLD;
                            out_q   <= res_d;
                            flags_q <= flags_d;
                            err_q   <= err_d;
                        end
                    end else if (state_q == ST_HOLD && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state_q <= ST_HOLD;
                        out_q   <= mul_prod;
                        flags_q <= mk_flags(mul_prod, 1'b0, 1'b0);
                        err_q   <= 1'b0;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed corner cases plus random traffic.
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] out;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inp1 = '0;
    logic [31:0] inp2 = '0;
    logic [3:0]  func = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [3:0]  flags;
    logic        err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    exp_t q[$];

    alu_seq dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: results straight from the arithmetic definition of each opcode
    function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        logic [63:0] wide;
        logic [31:0] r;
        logic [4:0] amt;
        bit c, v, legal;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        amt = b[4:0];
        c = 0; v = 0; legal = 1; r = '0;
        case (f)
            4'd1: begin
                wide = 64'(a) + 64'(b);
                r = wide[31:0];
                c = wide[32];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: begin
                r = a - b;
                c = (a < b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = ~a;
            4'd7: r = a << amt;
            4'd8: r = 32'($signed(a) >>> amt);
            4'd9: r = a >> amt;
            4'd10: begin
                wide = 64'(a) * 64'(b);
                r = wide[31:0];
                legal = MUL_ON;
            end
            default: legal = 0;
        endcase
        if (legal) begin
            e.out = r;
            e.flags = {r[31], (r == 32'd0), c, v};
            e.err = 1'b0;
        end else begin
            e.out = '0;
            e.flags = '0;
            e.err = 1'b1;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'($urandom_range(0, 1));
                1: out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: the presented result must always equal the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(out), 64'hDEAD);
                end else begin
                    e = q[0];
                    chk("sb_out", 64'(out), 64'(e.out));
                    chk("sb_flags", 64'(flags), 64'(e.flags));
                    chk("sb_err", 64'(err), 64'(e.err));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge (or after the result for MUL)
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit chk_lat);
        int n;
        bit bad;
        in_valid = 1'b1;
        func = f;
        inp1 = a;
        inp2 = b;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        q.push_back(model(f, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        func = 4'($urandom);
        inp1 = $urandom;
        inp2 = $urandom;
        if (chk_lat) begin
            if (f == 4'd10 && MUL_ON) begin
                n = 0;
                bad = 0;
                while (!out_valid && n < 100) begin
                    if (in_ready) bad = 1;
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("mul_latency", 64'(n), 64'(W + 1));
                chk("mul_in_ready_low", 64'(bad), 64'd0);
            end else begin
                chk("latency1_valid", 64'(out_valid), 64'd1);
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0;
        int n;
        bit seen;
        logic [3:0] f;
        int r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        rdy_mode = 1;

        issue(4'd1, 32'h7FFF_FFFF, 32'h1, 1);
        chk("add_ovf_out", 64'(out), 64'h8000_0000);
        chk("add_ovf_flags", 64'(flags), 64'b1001);
        issue(4'd2, 32'd5, 32'd7, 1);
        chk("sub_out", 64'(out), 64'hFFFF_FFFE);
        chk("sub_flags", 64'(flags), 64'b1010);

        t0 = cyc;
        issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
        issue(4'd4, 32'h1234_0000, 32'h0000_5678, 1);
        issue(4'd5, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1);
        chk("xor_zero_flags", 64'(flags), 64'b0100);
        chk("b2b_cycles", 64'(cyc - t0), 64'd3);

        issue(4'd8, 32'h8000_0000, 32'h21, 1);
        chk("sra_out", 64'(out), 64'hC000_0000);
        issue(4'd9, 32'h8000_0000, 32'h21, 1);
        chk("srl_out", 64'(out), 64'h4000_0000);

        issue(4'd10, 32'h0001_0000, 32'h0001_0001, 1);
        chk("mul_out", 64'(out), MUL_ON ? 64'h0001_0000 : 64'h0);
        chk("mul_err", 64'(err), MUL_ON ? 64'd0 : 64'd1);

        issue(4'hF, 32'h1234, 32'h5678, 1);
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_out", 64'(out), 64'd0);
        @(posedge clk);
        #1;

        // Stall: result must hold while the consumer is not ready
        rdy_mode = 2;
        issue(4'd1, 32'd10, 32'd20, 1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (in_ready || !out_valid || out != 32'd30) seen = 1;
        end
        chk("stall_hold", 64'(seen), 64'd0);
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a result is held
        rdy_mode = 2;
        issue(4'd3, 32'hFFFF_0000, 32'h0FF0_0FF0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        chk("rst_hold_out", 64'(out), 64'd0);
        q.delete();
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef ALU_SEQ_MUL_EN
        // Reset in the middle of a multiply
        issue(4'd10, 32'd1234, 32'd5678, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mul_valid", 64'(out_valid), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("no_result_after_rst", 64'(seen), 64'd0);
        issue(4'd1, 32'd2, 32'd3, 1);
        chk("add_after_rst", 64'(out), 64'd5);

        // Random traffic with random back-pressure
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            f = (r < 16) ? 4'(r) : 4'($urandom_range(1, 9));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(f, pick(), pick(), 1);
        end

        rdy_mode = 1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
